// File: rtl/ibex_pkg.sv
// Shared types and constants for the CHERI capability load/store sequencer.
`default_nettype none

package ibex_pkg;

  typedef enum logic [1:0] {
    CAP_LSU_IDLE        = 2'd0,
    CAP_LSU_REQ         = 2'd1,
    CAP_LSU_WAIT_RVALID = 2'd2,
    CAP_LSU_DONE        = 2'd3
  } cap_lsu_state_e;

  localparam int unsigned CapMemBeats  = 3;
  localparam int unsigned CapAlignBits = 4;

endpackage

`default_nettype wire

// File: rtl/ibex_cheri_cap_lsu.sv
// Capability load/store sequencer: splits a tagged capability into 32-bit bus
// beats (one outstanding), reassembles loads and emits a single completion pulse.
`default_nettype none

module ibex_cheri_cap_lsu
  import ibex_pkg::*;
#(
  parameter int unsigned CheriCapWidth = 91
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     lsu_req_i,
  input  logic                     lsu_we_i,
  input  logic [31:0]              lsu_addr_i,
  input  logic [CheriCapWidth-1:0] lsu_wcap_i,
  output logic                     lsu_busy_o,
  output logic                     lsu_valid_o,
  output logic                     lsu_err_o,
  output logic                     lsu_err_misaligned_o,
  output logic [CheriCapWidth-1:0] lsu_rcap_o,
  output logic                     data_req_o,
  input  logic                     data_gnt_i,
  input  logic                     data_rvalid_i,
  input  logic                     data_err_i,
  output logic [31:0]              data_addr_o,
  output logic                     data_we_o,
  output logic [3:0]               data_be_o,
  output logic [31:0]              data_wdata_o,
  output logic                     data_wtag_o,
  input  logic [31:0]              data_rdata_i,
  input  logic                     data_rtag_i
);

  // Width of the final, partially populated beat (26 bits for a 91-bit capability).
  localparam int unsigned LastBeatW = CheriCapWidth - 1 - 32 * (CapMemBeats - 1);
  localparam logic [1:0]  LastBeat  = 2'(CapMemBeats - 1);

  cap_lsu_state_e             state_q, state_d;
  logic [1:0]                 beat_q;
  logic [31:CapAlignBits]     addr_q;
  logic                       we_q;
  logic [CheriCapWidth-1:0]   wcap_q;
  logic                       tag_q;
  logic [CheriCapWidth-2:0]   rbuf_q;
  logic                       err_q;
  logic                       mis_q;
  logic                       misaligned;
  logic [31:0]                beat_wdata;

  assign misaligned = |lsu_addr_i[CapAlignBits-1:0];

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      CAP_LSU_IDLE: begin
        if (lsu_req_i) begin
          state_d = misaligned ? CAP_LSU_DONE : CAP_LSU_REQ;
        end
      end
      CAP_LSU_REQ: begin
        if (data_gnt_i) begin
          state_d = CAP_LSU_WAIT_RVALID;
        end
      end
      CAP_LSU_WAIT_RVALID: begin
        if (data_rvalid_i) begin
          state_d = (data_err_i || beat_q == LastBeat) ? CAP_LSU_DONE : CAP_LSU_REQ;
        end
      end
      CAP_LSU_DONE: state_d = CAP_LSU_IDLE;
      default:      state_d = CAP_LSU_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= CAP_LSU_IDLE;
      beat_q  <= 2'd0;
      addr_q  <= '0;
      we_q    <= 1'b0;
      wcap_q  <= '0;
      tag_q   <= 1'b1;
      rbuf_q  <= '0;
      err_q   <= 1'b0;
      mis_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      case (state_q)
        CAP_LSU_IDLE: begin
          if (lsu_req_i) begin
            err_q <= misaligned;
            mis_q <= misaligned;
            we_q  <= lsu_we_i;
            if (!misaligned) begin
              addr_q <= lsu_addr_i[31:CapAlignBits];
              wcap_q <= lsu_wcap_i;
              beat_q <= 2'd0;
              tag_q  <= 1'b1;
            end
          end
        end
        CAP_LSU_WAIT_RVALID: begin
          if (data_rvalid_i) begin
            if (data_err_i) begin
              err_q <= 1'b1;
              mis_q <= 1'b0;
            end else begin
              if (!we_q) begin
                // The last beat only carries LastBeatW capability bits; the pad is dropped.
                if (beat_q == LastBeat) begin
                  rbuf_q[CheriCapWidth-2 -: LastBeatW] <= data_rdata_i[LastBeatW-1:0];
                end else begin
                  rbuf_q[{beat_q, 5'b0} +: 32] <= data_rdata_i;
                end
                tag_q <= tag_q & data_rtag_i;
              end
              if (beat_q != LastBeat) begin
                beat_q <= beat_q + 2'd1;
              end
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    beat_wdata = '0;
    if (beat_q == LastBeat) begin
      beat_wdata[LastBeatW-1:0] = wcap_q[CheriCapWidth-2 -: LastBeatW];
    end else begin
      beat_wdata = wcap_q[{beat_q, 5'b0} +: 32];
    end
  end

  assign lsu_busy_o           = (state_q != CAP_LSU_IDLE);
  assign lsu_valid_o          = (state_q == CAP_LSU_DONE);
  assign lsu_err_o            = lsu_valid_o & err_q;
  assign lsu_err_misaligned_o = lsu_valid_o & mis_q;
  assign lsu_rcap_o           = (lsu_valid_o && !err_q && !we_q) ? {tag_q, rbuf_q} : '0;

  assign data_req_o   = (state_q == CAP_LSU_REQ);
  assign data_addr_o  = data_req_o ? {addr_q, beat_q, 2'b00} : 32'd0;
  assign data_we_o    = data_req_o & we_q;
  assign data_be_o    = data_req_o ? 4'b1111 : 4'b0000;
  assign data_wdata_o = data_req_o ? beat_wdata : 32'd0;
  assign data_wtag_o  = data_req_o & we_q & wcap_q[CheriCapWidth-1];

endmodule

`default_nettype wire

// File: tb/tb_ibex_cheri_cap_lsu.sv
// Directed, table-driven bench for the capability load/store sequencer.
`default_nettype none

module tb_ibex_cheri_cap_lsu;

  logic        clk = 1'b0;
  logic        rst_i;
  logic        lsu_req_i;
  logic        lsu_we_i;
  logic [31:0] lsu_addr_i;
  logic [90:0] lsu_wcap_i;
  logic        lsu_busy_o, lsu_valid_o, lsu_err_o, lsu_err_misaligned_o;
  logic [90:0] lsu_rcap_o;
  logic        data_req_o, data_gnt_i, data_rvalid_i, data_err_i;
  logic [31:0] data_addr_o;
  logic        data_we_o;
  logic [3:0]  data_be_o;
  logic [31:0] data_wdata_o;
  logic        data_wtag_o;
  logic [31:0] data_rdata_i;
  logic        data_rtag_i;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  ibex_cheri_cap_lsu #(.CheriCapWidth(91)) dut (
    .clk_i               (clk),
    .rst_i               (rst_i),
    .lsu_req_i           (lsu_req_i),
    .lsu_we_i            (lsu_we_i),
    .lsu_addr_i          (lsu_addr_i),
    .lsu_wcap_i          (lsu_wcap_i),
    .lsu_busy_o          (lsu_busy_o),
    .lsu_valid_o         (lsu_valid_o),
    .lsu_err_o           (lsu_err_o),
    .lsu_err_misaligned_o(lsu_err_misaligned_o),
    .lsu_rcap_o          (lsu_rcap_o),
    .data_req_o          (data_req_o),
    .data_gnt_i          (data_gnt_i),
    .data_rvalid_i       (data_rvalid_i),
    .data_err_i          (data_err_i),
    .data_addr_o         (data_addr_o),
    .data_we_o           (data_we_o),
    .data_be_o           (data_be_o),
    .data_wdata_o        (data_wdata_o),
    .data_wtag_o         (data_wtag_o),
    .data_rdata_i        (data_rdata_i),
    .data_rtag_i         (data_rtag_i)
  );

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [90:0] wcap;
    logic [95:0] rdata;      // beat b in [32*b+31:32*b]
    logic [2:0]  rtag;
    logic [2:0]  berr;
    logic [2:0]  gnt_wait;   // cycles grant is withheld on beat 0
    logic [95:0] exp_wdata;
    logic [1:0]  exp_beats;
    logic        exp_err;
    logic        exp_mis;
    logic [90:0] exp_rcap;
    logic [3:0]  exp_lat;
  } vec_t;

  localparam int NVEC = 8;
  vec_t vecs [NVEC];

  task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_idle();
    data_gnt_i    = 1'b0;
    data_rvalid_i = 1'b0;
    data_err_i    = 1'b0;
    data_rdata_i  = 32'd0;
    data_rtag_i   = 1'b0;
  endtask

  task automatic run_vec(input vec_t v, input int id);
    int          cyc   = 1;
    int          beat  = 0;
    int          waits = 0;
    bit          pend  = 1'b0;
    bit          done  = 1'b0;
    logic [95:0] rd    = v.rdata;
    logic [95:0] wd    = v.exp_wdata;
    logic [2:0]  rt    = v.rtag;
    logic [2:0]  be    = v.berr;
    string       p     = $sformatf("v%0d", id);
    lsu_req_i  = 1'b1;
    lsu_we_i   = v.we;
    lsu_addr_i = v.addr;
    lsu_wcap_i = v.wcap;
    tick();
    lsu_req_i = 1'b0;
    while (!done && cyc <= 40) begin
      bus_idle();
      chk({p, "_busy"}, 96'(lsu_busy_o), 96'd1);
      if (pend) begin
        data_rvalid_i = 1'b1;
        data_rdata_i  = rd[32*beat +: 32];
        data_rtag_i   = rt[beat];
        data_err_i    = be[beat];
        pend = 1'b0;
        beat++;
      end else if (data_req_o) begin
        if (beat >= int'(v.exp_beats)) begin
          chk({p, "_extra_req"}, 96'(beat), 96'(v.exp_beats) - 96'd1);
        end else begin
          chk({p, "_addr"}, 96'(data_addr_o), 96'({v.addr[31:4], 4'b0} + 32'(4 * beat)));
          chk({p, "_we"}, 96'(data_we_o), 96'(v.we));
          chk({p, "_be"}, 96'(data_be_o), 96'hF);
          if (v.we) begin
            chk({p, "_wdata"}, 96'(data_wdata_o), 96'(wd[32*beat +: 32]));
            chk({p, "_wtag"}, 96'(data_wtag_o), 96'(v.wcap[90]));
          end
          if (beat == 0 && waits < int'(v.gnt_wait)) begin
            waits++;
          end else begin
            if (v.gnt_wait == 0) chk({p, "_req_cycle"}, 96'(cyc), 96'(1 + 2 * beat));
            data_gnt_i = 1'b1;
            pend = 1'b1;
          end
        end
      end
      if (lsu_valid_o) begin
        chk({p, "_latency"}, 96'(cyc), 96'(v.exp_lat));
        chk({p, "_err"}, 96'(lsu_err_o), 96'(v.exp_err));
        chk({p, "_mis"}, 96'(lsu_err_misaligned_o), 96'(v.exp_mis));
        chk({p, "_rcap"}, 96'(lsu_rcap_o), 96'(v.exp_rcap));
        chk({p, "_beats"}, 96'(beat), 96'(v.exp_beats));
        done = 1'b1;
      end
      tick();
      cyc++;
    end
    if (!done) chk({p, "_timeout"}, 96'd1, 96'd0);
    bus_idle();
    chk({p, "_busy_after"}, 96'(lsu_busy_o), 96'd0);
    chk({p, "_valid_after"}, 96'(lsu_valid_o), 96'd0);
  endtask

  initial begin
    // Store data: tag 1, [89:64]=26'h2AABBBB, [63:32]=CCCCDDDD, [31:0]=EEEEFFFF
    vecs[0] = '{we: 1'b1, addr: 32'h0000_1000,
                wcap: {1'b1, 26'h2AABBBB, 32'hCCCCDDDD, 32'hEEEEFFFF},
                rdata: '0, rtag: 3'b000, berr: 3'b000, gnt_wait: 3'd0,
                exp_wdata: {32'h02AABBBB, 32'hCCCCDDDD, 32'hEEEEFFFF},
                exp_beats: 2'd3, exp_err: 1'b0, exp_mis: 1'b0, exp_rcap: '0, exp_lat: 4'd7};
    vecs[1] = '{we: 1'b0, addr: 32'h0000_2000, wcap: '0,
                rdata: {32'hFFFFFFF3, 32'h22222222, 32'h11111111},
                rtag: 3'b111, berr: 3'b000, gnt_wait: 3'd0, exp_wdata: '0,
                exp_beats: 2'd3, exp_err: 1'b0, exp_mis: 1'b0,
                exp_rcap: {1'b1, 26'h3FFFFF3, 32'h22222222, 32'h11111111}, exp_lat: 4'd7};
    vecs[2] = '{we: 1'b0, addr: 32'h0000_2000, wcap: '0,
                rdata: {32'hFFFFFFF3, 32'h22222222, 32'h11111111},
                rtag: 3'b101, berr: 3'b000, gnt_wait: 3'd0, exp_wdata: '0,
                exp_beats: 2'd3, exp_err: 1'b0, exp_mis: 1'b0,
                exp_rcap: {1'b0, 26'h3FFFFF3, 32'h22222222, 32'h11111111}, exp_lat: 4'd7};
    vecs[3] = '{we: 1'b0, addr: 32'h0000_1008, wcap: '0, rdata: '0,
                rtag: 3'b111, berr: 3'b000, gnt_wait: 3'd0, exp_wdata: '0,
                exp_beats: 2'd0, exp_err: 1'b1, exp_mis: 1'b1, exp_rcap: '0, exp_lat: 4'd1};
    vecs[4] = '{we: 1'b1, addr: 32'h0000_0001, wcap: {1'b1, 90'h1}, rdata: '0,
                rtag: 3'b000, berr: 3'b000, gnt_wait: 3'd0, exp_wdata: '0,
                exp_beats: 2'd0, exp_err: 1'b1, exp_mis: 1'b1, exp_rcap: '0, exp_lat: 4'd1};
    // Top of address space, tag-clear store with full last beat.
    vecs[5] = '{we: 1'b1, addr: 32'hFFFF_FFF0,
                wcap: {1'b0, 26'h3FFFFFF, 32'h00000000, 32'h12345678},
                rdata: '0, rtag: 3'b000, berr: 3'b000, gnt_wait: 3'd0,
                exp_wdata: {32'h03FFFFFF, 32'h00000000, 32'h12345678},
                exp_beats: 2'd3, exp_err: 1'b0, exp_mis: 1'b0, exp_rcap: '0, exp_lat: 4'd7};
    // Grant withheld 3 cycles on beat 0, bus error on beat 1.
    vecs[6] = '{we: 1'b1, addr: 32'h0000_4000,
                wcap: {1'b1, 26'h2AABBBB, 32'hCCCCDDDD, 32'hEEEEFFFF},
                rdata: '0, rtag: 3'b000, berr: 3'b010, gnt_wait: 3'd3,
                exp_wdata: {32'h02AABBBB, 32'hCCCCDDDD, 32'hEEEEFFFF},
                exp_beats: 2'd2, exp_err: 1'b1, exp_mis: 1'b0, exp_rcap: '0, exp_lat: 4'd8};
    vecs[7] = '{we: 1'b0, addr: 32'h0000_5000, wcap: '0,
                rdata: {32'h0, 32'h0, 32'hDEADBEEF}, rtag: 3'b111, berr: 3'b001,
                gnt_wait: 3'd0, exp_wdata: '0, exp_beats: 2'd1, exp_err: 1'b1,
                exp_mis: 1'b0, exp_rcap: '0, exp_lat: 4'd3};

    rst_i      = 1'b1;
    lsu_req_i  = 1'b0;
    lsu_we_i   = 1'b0;
    lsu_addr_i = 32'd0;
    lsu_wcap_i = '0;
    bus_idle();
    repeat (3) tick();
    chk("rst_busy", 96'(lsu_busy_o), 96'd0);
    chk("rst_valid", 96'(lsu_valid_o), 96'd0);
    chk("rst_req", 96'(data_req_o), 96'd0);
    chk("rst_rcap", 96'(lsu_rcap_o), 96'd0);
    chk("rst_addr", 96'(data_addr_o), 96'd0);
    rst_i = 1'b0;
    tick();

    // Vectors run back to back: each request is issued the cycle after DONE.
    for (int i = 0; i < NVEC; i++) run_vec(vecs[i], i);

    // Reset during WAIT_RVALID of beat 1 aborts silently.
    lsu_req_i  = 1'b1;
    lsu_we_i   = 1'b0;
    lsu_addr_i = 32'h0000_3000;
    tick();
    lsu_req_i = 1'b0;
    chk("ro_req0", 96'(data_req_o), 96'd1);
    data_gnt_i = 1'b1;
    tick();
    data_gnt_i    = 1'b0;
    data_rvalid_i = 1'b1;
    data_rdata_i  = 32'hA5A5A5A5;
    data_rtag_i   = 1'b1;
    tick();
    bus_idle();
    chk("ro_req1", 96'(data_req_o), 96'd1);
    chk("ro_addr1", 96'(data_addr_o), 96'h3004);
    data_gnt_i = 1'b1;
    tick();
    data_gnt_i = 1'b0;
    chk("ro_wait_busy", 96'(lsu_busy_o), 96'd1);
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    chk("ro_busy", 96'(lsu_busy_o), 96'd0);
    chk("ro_valid", 96'(lsu_valid_o), 96'd0);
    chk("ro_dreq", 96'(data_req_o), 96'd0);
    data_rvalid_i = 1'b1;
    data_rdata_i  = 32'h5A5A5A5A;
    data_rtag_i   = 1'b1;
    tick();
    bus_idle();
    chk("ro_late_valid", 96'(lsu_valid_o), 96'd0);
    chk("ro_late_busy", 96'(lsu_busy_o), 96'd0);
    tick();
    chk("ro_idle_valid", 96'(lsu_valid_o), 96'd0);
    run_vec(vecs[2], 100);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
